uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_mem.sv | 19 +
 rtl/uart_tx_fifo.sv | 84 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: launch FSM state encoding and byte width shared by the UART TX FIFO
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } launch_state_e;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x 8 storage, synchronous write, asynchronous read, never cleared
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);
  logic [UART_DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a serializer through a launch FSM; UART_TX_FIFO_OVERFLOW_EN adds a sticky overflow flag
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [UART_DATA_W-1:0] wrData,
  input  logic                   wrEn,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic [UART_DATA_W-1:0] txByte,
  output logic                   txTrig,
`ifdef UART_TX_FIFO_OVERFLOW_EN
  output logic                   overflow,
`endif
  input  logic                   txRdy
);
  launch_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, tx_trig_q, tx_trig_d, wr_acc, pop;
  logic [UART_DATA_W-1:0] tx_byte_q, tx_byte_d, rd_data;
  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(wrData),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );
  // full_q gates the write even when a pop lands in the same cycle
  always_comb begin
    wr_acc    = wrEn && !full_q;
    pop       = (state_q == IDLE) && !empty_q && txRdy;
    count_d   = count_q + (AW+1)'(wr_acc) - (AW+1)'(pop);
    wr_ptr_d  = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    full_d    = count_d == (AW+1)'(DEPTH);
    empty_d   = count_d == '0;
    tx_byte_d = pop ? rd_data : tx_byte_q;
    tx_trig_d = state_q == LAUNCH;
    state_d   = pop                               ? LAUNCH    :
                (state_q == LAUNCH)               ? WAIT_BUSY :
                (state_q == WAIT_BUSY && !txRdy)  ? WAIT_DONE :
                (state_q == WAIT_DONE && txRdy)   ? IDLE      : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      tx_byte_q <= '0;
      tx_trig_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      tx_byte_q <= tx_byte_d;
      tx_trig_q <= tx_trig_d;
    end
  end
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;
  always_comb overflow_d = overflow_q || (wrEn && full_q);
  always_ff @(posedge clk)
    overflow_q <= !rstN ? 1'b0 : overflow_d;
  assign overflow = overflow_q;
`endif
  assign full   = full_q;
  assign empty  = empty_q;
  assign count  = count_q;
  assign txByte = tx_byte_q;
  assign txTrig = tx_trig_q;
endmodule
